iter_div: RTL and testbench

Iterative radix-2 divider that sits beside `boothmul` in the execute-stage ALU. It takes a dividend/divisor pair over a valid/ready handshake and performs one restoring step per cycle. It returns a 32-bit quotient and remainder, signed or unsigned. It is the inverse operation to the multiplier and shares its clock, reset and handshake style, so the same bench harness drives both.

---
 rtl/div_pkg.sv | 7 +
 rtl/div_step.sv | 17 +
 rtl/iter_div.sv | 116 +++++++++++
 tb/tb_iter_div.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam logic [DIV_WIDTH-1:0] DIV0_Q = '1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;
endpackage

// File: rtl/div_step.sv
// One combinational restoring step: shift, trial subtract, shift in a quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] i_pr,
    input  logic [WIDTH-1:0] i_d,
    output logic [2*WIDTH:0] o_pr
);
    logic [2*WIDTH+1:0] w_shift;
    logic [WIDTH+1:0]   w_diff;

    // Upper field is always below the divisor, so the shifted value fits W+1 bits.
    assign w_shift = {i_pr, 1'b0};
    assign w_diff  = w_shift[2*WIDTH+1:WIDTH] - {2'b00, i_d};
    assign o_pr    = w_diff[WIDTH+1] ? w_shift[2*WIDTH:0]
                                     : {w_diff[WIDTH:0], w_shift[WIDTH-1:1], 1'b1};
endmodule

// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider, signed/unsigned, valid/ready on both sides.
module iter_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             mul_clk,
    input  logic             resetn,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] L_Q_DIV0  = WIDTH'(DIV0_Q);
    localparam logic [WIDTH-1:0] L_INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       r_state;
    logic [CW-1:0]    r_cnt;
    logic [2*WIDTH:0] r_pr;
    logic [WIDTH-1:0] r_ymag;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_x_neg;
    logic             w_y_neg;
    logic [WIDTH-1:0] w_x_mag;
    logic [WIDTH-1:0] w_y_mag;
    logic             w_ovf;
    logic [2*WIDTH:0] w_pr_next;

    assign w_x_neg = div_signed & x[WIDTH-1];
    assign w_y_neg = div_signed & y[WIDTH-1];
    assign w_x_mag = w_x_neg ? -x : x;
    assign w_y_mag = w_y_neg ? -y : y;
    assign w_ovf   = div_signed && (x == L_INT_MIN) && (y == '1);

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_pr (r_pr),
        .i_d  (r_ymag),
        .o_pr (w_pr_next)
    );

    always_ff @(posedge mul_clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_pr        <= '0;
            r_ymag      <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_in_ready <= 1'b0;
                    r_cnt      <= '0;
                    r_ymag     <= w_y_mag;
                    // Special cases preload the final answer and pass through FIX
                    // with signs cleared, so they surface one cycle after accept.
                    if (y == '0) begin
                        r_pr    <= {1'b0, x, L_Q_DIV0};
                        r_q_neg <= 1'b0;
                        r_r_neg <= 1'b0;
                        r_state <= FIX;
                    end else if (w_ovf) begin
                        r_pr    <= {1'b0, {WIDTH{1'b0}}, L_INT_MIN};
                        r_q_neg <= 1'b0;
                        r_r_neg <= 1'b0;
                        r_state <= FIX;
                    end else begin
                        r_pr    <= {{(WIDTH+1){1'b0}}, w_x_mag};
                        r_q_neg <= w_x_neg ^ w_y_neg;
                        r_r_neg <= w_x_neg;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_pr  <= w_pr_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH-1))
                        r_state <= FIX;
                end
                FIX: begin
                    r_quotient  <= r_q_neg ? -r_pr[WIDTH-1:0] : r_pr[WIDTH-1:0];
                    r_remainder <= r_r_neg ? -r_pr[2*WIDTH-1:WIDTH] : r_pr[2*WIDTH-1:WIDTH];
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
endmodule

// File: tb/tb_iter_div.sv
// Randomized bench for iter_div against an arithmetic reference model.
module tb_iter_div;
    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } res_t;

    logic        mul_clk = 1'b0;
    logic        resetn = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int   total = 0;
    int   bad = 0;
    res_t exp_q[$];

    iter_div #(.WIDTH(32)) dut (
        .mul_clk    (mul_clk),
        .resetn     (resetn),
        .div_signed (div_signed),
        .x          (x),
        .y          (y),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 mul_clk = ~mul_clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain language-level division; longint makes INT_MIN/-1 wrap naturally.
    function automatic res_t model(bit s, logic [31:0] a, logic [31:0] b);
        res_t   e;
        longint sa, sb;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end else if (s) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            e.q = 32'(sa / sb);
            e.r = 32'(sa % sb);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    function automatic int model_lat(bit s, logic [31:0] a, logic [31:0] b);
        if (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            return 1;
        return 33;
    endfunction

    // Single compare process: whenever a result is presented, it must match the model.
    always @(negedge mul_clk) begin
        if (resetn && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                chk("quotient", 64'(quotient), 64'(exp_q[0].q));
                chk("remainder", 64'(remainder), 64'(exp_q[0].r));
                chk("in_ready_in_done", 64'(in_ready), 64'd0);
                if (out_ready)
                    void'(exp_q.pop_front());
            end
        end
    end

    task automatic run_op(bit s, logic [31:0] a, logic [31:0] b, bit hold);
        res_t e;
        int   n;
        bit   busy_bad;
        e = model(s, a, b);
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge mul_clk); #1; n++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        out_ready  = !hold;
        div_signed = s;
        x          = a;
        y          = b;
        in_valid   = 1'b1;
        @(posedge mul_clk); #1;
        exp_q.push_back(e);
        in_valid   = 1'b0;
        x          = $urandom;
        y          = $urandom;
        div_signed = 1'($urandom);
        n          = 0;
        busy_bad   = 1'b0;
        while (!out_valid && n < 100) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge mul_clk); #1; n++;
        end
        chk("latency", 64'(n), 64'(model_lat(s, a, b)));
        chk("in_ready_busy", 64'(busy_bad), 64'd0);
        if (hold) begin
            repeat (5) begin
                @(posedge mul_clk); #1;
                chk("hold_out_valid", 64'(out_valid), 64'd1);
                chk("hold_in_ready", 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
        end
        @(posedge mul_clk); #1;
        chk("post_handoff_in_ready", 64'(in_ready), 64'd1);
        chk("post_handoff_out_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic chk_idle(string nm);
        chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({nm, "_quotient"}, 64'(quotient), 64'd0);
        chk({nm, "_remainder"}, 64'(remainder), 64'd0);
    endtask

    initial begin
        res_t        m;
        bit          s;
        logic [31:0] a, b;

        repeat (2) @(posedge mul_clk);
        #1;
        chk_idle("reset");
        resetn = 1'b1;

        // Hand-computed anchors for the model itself.
        m = model(1'b0, 32'd100, 32'd7);
        chk("model_u_100_7", 64'(m), {32'd14, 32'd2});
        m = model(1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("model_s_m7_2", 64'(m), {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        m = model(1'b0, 32'hFFFF_FFF9, 32'd2);
        chk("model_u_m7_2", 64'(m), {32'h7FFF_FFFC, 32'd1});
        m = model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("model_ovf", 64'(m), {32'h8000_0000, 32'd0});
        m = model(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("model_u_ovf_ops", 64'(m), {32'd0, 32'h8000_0000});
        m = model(1'b1, 32'h0000_1234, 32'd0);
        chk("model_div0", 64'(m), {32'hFFFF_FFFF, 32'h0000_1234});

        @(posedge mul_clk); #1;
        run_op(1'b0, 32'd100, 32'd7, 1'b0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(1'b0, 32'h0000_1234, 32'd0, 1'b0);
        run_op(1'b1, 32'h0000_1234, 32'd0, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);

        // Reset ten cycles into a calculation discards it.
        div_signed = 1'b0;
        x          = 32'd100;
        y          = 32'd7;
        in_valid   = 1'b1;
        @(posedge mul_clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge mul_clk);
        #1;
        resetn = 1'b0;
        exp_q.delete();
        @(posedge mul_clk); #1;
        chk_idle("mid_calc_reset");
        resetn = 1'b1;
        repeat (40) begin
            @(posedge mul_clk); #1;
            if (out_valid) break;
        end
        chk("no_result_after_reset", 64'(out_valid), 64'd0);
        run_op(1'b0, 32'd100, 32'd7, 1'b0);

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if (i % 9 == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            run_op(s, a, b, ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(posedge mul_clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end
endmodule
